// File: rtl/gemm_axis_sender.sv
// gemm_axis_sender: streams result-buffer words onto an AXI-Stream master.
// A transfer length is captured on start; words are read from a 1-cycle
// latency RAM into a 2-entry skid FIFO whose head drives the stream.
module gemm_axis_sender #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESETN,
  input  logic                start,
  input  logic [ADDR_W:0]     size,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                M_AXIS_TVALID,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TSTRB,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  size_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  snd_cnt_q;
  logic              pend_q;
  logic              head_v_q;
  logic              tail_v_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;

  logic              load;
  logic              pop;
  logic              push;
  logic [1:0]        occ_after;

  // A beat leaves the head on handshake; the RAM word issued last cycle arrives now.
  assign pop  = head_v_q & M_AXIS_TREADY;
  assign push = pend_q;

  // Occupancy once this cycle's pop is taken out; counting the pop keeps
  // reads flowing back-to-back when the sink is always ready.
  assign occ_after = {1'b0, head_v_q} + {1'b0, tail_v_q} - {1'b0, pop};

  // Never let stored words plus the in-flight read exceed the two FIFO slots.
  assign rd_en   = (state_q == S_RUN) && (rd_cnt_q < size_q) &&
                   ((occ_after + {1'b0, pend_q}) < 2'd2);
  assign rd_addr = rd_cnt_q[ADDR_W-1:0];

  assign M_AXIS_TVALID = head_v_q;
  assign M_AXIS_TDATA  = head_q;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = head_v_q && (snd_cnt_q == size_q - CNT_W'(1));

  // State register.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (size != '0) begin
            load    = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // Leave as soon as the final read is issued.
        if ((rd_en && (rd_cnt_q + CNT_W'(1) == size_q)) || (rd_cnt_q >= size_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final handshake empties everything, so DONE follows it directly.
        if ((pop && M_AXIS_TLAST) ||
            ((snd_cnt_q == size_q) && !head_v_q && !tail_v_q && !pend_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer length plus read and send counters.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      size_q    <= '0;
      rd_cnt_q  <= '0;
      snd_cnt_q <= '0;
    end else if (load) begin
      size_q    <= size;
      rd_cnt_q  <= '0;
      snd_cnt_q <= '0;
    end else begin
      if (rd_en) rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
      if (pop)   snd_cnt_q <= snd_cnt_q + CNT_W'(1);
    end
  end

  // In-flight read marker; reset drops any read that is still returning.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= rd_en;
    end
  end

  // Two-entry skid FIFO: head drives the stream, tail catches a word during a stall.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else if (pop) begin
      if (tail_v_q) begin
        head_q   <= tail_q;
        tail_v_q <= push;
        if (push) tail_q <= rd_data;
      end else begin
        head_v_q <= push;
        if (push) head_q <= rd_data;
      end
    end else if (push) begin
      if (!head_v_q) begin
        head_q   <= rd_data;
        head_v_q <= 1'b1;
      end else begin
        tail_q   <= rd_data;
        tail_v_q <= 1'b1;
      end
    end
  end

endmodule
